// File: rtl/dual_priority_decoder.sv
// dual_priority_decoder: rebuilds a request vector from two encoded indices into a 2-entry FIFO.
// Optional malformed-word checking and error counting is enabled by macro DPD_CHECK_EN.
`default_nettype none

module dual_priority_decoder #(
   parameter int REQ_WIDTH = 12,
   parameter int IDX_W     = $clog2(REQ_WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IDX_W-1:0]     in_first,
   input  logic [IDX_W-1:0]     in_second,
   input  logic                 in_second_vld,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REQ_WIDTH-1:0] out_req,
   output logic                 out_err,
   output logic [7:0]           err_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   push;
   logic                   pop;
   logic [REQ_WIDTH-1:0]   dec_req;
   logic                   dec_err;
   logic [REQ_WIDTH-1:0]   head_req;
   logic [REQ_WIDTH-1:0]   tail_req;
   logic                   head_err;
   logic                   tail_err;

   assign push = in_valid && in_ready;
   assign pop  = (state != EMPTY) && out_ready;

   // Indices at or above REQ_WIDTH match no loop position, so they add no bit.
   always_comb begin
      dec_req = '0;
      for (int i = 0; i < REQ_WIDTH; i++) begin
         if ((in_first == IDX_W'(i)) || (in_second_vld && (in_second == IDX_W'(i)))) begin
            dec_req[i] = 1'b1;
         end
      end
   end

`ifdef DPD_CHECK_EN
   always_comb begin
      dec_err = (int'(in_first) >= REQ_WIDTH)
             || (in_second_vld && (int'(in_second) >= REQ_WIDTH))
             || (in_second_vld && (in_second >= in_first));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= 8'd0;
      end else if (push && dec_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign dec_err = 1'b0;
   assign err_cnt = 8'd0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (push) state_nxt = ONE;
         ONE: begin
            if (push && !pop)      state_nxt = FULL;
            else if (pop && !push) state_nxt = EMPTY;
         end
         FULL:  if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
         head_req <= '0;
         tail_req <= '0;
         head_err <= 1'b0;
         tail_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         // Registered ready: a pop from FULL frees a slot only from the next cycle on.
         in_ready <= (state_nxt != FULL);
         case (state)
            EMPTY: begin
               if (push) begin
                  head_req <= dec_req;
                  head_err <= dec_err;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_req <= dec_req;
                  head_err <= dec_err;
               end else if (push) begin
                  tail_req <= dec_req;
                  tail_err <= dec_err;
               end
            end
            FULL: begin
               if (pop) begin
                  head_req <= tail_req;
                  head_err <= tail_err;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state != EMPTY);
   assign out_req   = out_valid ? head_req : '0;
   assign out_err   = out_valid && head_err;

endmodule

`default_nettype wire

// File: tb/tb_dual_priority_decoder.sv
// Testbench for dual_priority_decoder: directed steps then random traffic against a queue model.
`default_nettype none

module tb_dual_priority_decoder;

   localparam int W  = 12;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_first;
   logic [IW-1:0] in_second;
   logic          in_second_vld;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_req;
   logic          out_err;
   logic [7:0]    err_cnt;

   dual_priority_decoder #(.REQ_WIDTH(W), .IDX_W(IW)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_first      (in_first),
      .in_second     (in_second),
      .in_second_vld (in_second_vld),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_req       (out_req),
      .out_err       (out_err),
      .err_cnt       (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] req;
      logic         err;
   } ent_t;

   ent_t q[$];
   bit   m_ready;
   int   m_cnt;
   int   n_cmp;
   int   n_bad;

   function automatic logic [W-1:0] model_req(int f, int s, bit sv);
      logic [31:0] v;
      v = 32'd0;
      if (f < W)       v = v | (32'd1 << f);
      if (sv && s < W) v = v | (32'd1 << s);
      return v[W-1:0];
   endfunction

   function automatic bit model_err(int f, int s, bit sv);
`ifdef DPD_CHECK_EN
      return (f >= W) || (sv && (s >= W || s >= f));
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the model with the inputs present at the edge, then compare.
   task automatic cycle();
      bit   psh;
      bit   pp;
      ent_t e;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_ready = 1'b0;
         m_cnt   = 0;
      end else begin
         psh = in_valid && m_ready;
         pp  = (q.size() > 0) && out_ready;
         if (pp) void'(q.pop_front());
         if (psh) begin
            e.req = model_req(int'(in_first), int'(in_second), in_second_vld);
            e.err = model_err(int'(in_first), int'(in_second), in_second_vld);
            q.push_back(e);
            if (e.err && m_cnt < 255) m_cnt++;
         end
         m_ready = (q.size() != 2);
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("out_req",   32'(out_req),   (q.size() > 0) ? 32'(q[0].req) : 32'd0);
      check("out_err",   32'(out_err),   (q.size() > 0) ? 32'(q[0].err) : 32'd0);
      check("in_ready",  32'(in_ready),  32'(m_ready));
      check("err_cnt",   32'(err_cnt),   32'(m_cnt));
   endtask

   task automatic word(input int f, input int s, input bit sv);
      in_valid      = 1'b1;
      in_first      = IW'(f);
      in_second     = IW'(s);
      in_second_vld = sv;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; m_ready = 1'b0; m_cnt = 0;
      reset = 1'b1; in_valid = 1'b0; in_first = '0; in_second = '0;
      in_second_vld = 1'b0; out_ready = 1'b0;

      // reset state and ready rising on the first released edge
      cycle(); cycle();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      cycle();
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // basic decode with one-cycle latency
      word(11, 3, 1'b1); out_ready = 1'b1;
      cycle();
      check("dec_808", 32'(out_req), 32'h808);
      check("dec_808_vld", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      cycle();

      // backpressure: three offers, two accepted, outputs frozen
      out_ready = 1'b0;
      word(1, 0, 1'b0); cycle();
      word(2, 0, 1'b0); cycle();
      word(3, 0, 1'b0); cycle();
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("frozen_req", 32'(out_req), 32'h002);
      in_valid = 1'b0; out_ready = 1'b1; cycle();
      check("after_pop_ready", 32'(in_ready), 32'd1);
      check("after_pop_req", 32'(out_req), 32'h004);
      cycle();
      check("drained", 32'(out_valid), 32'd0);

      // one entry, simultaneous push and pop
      out_ready = 1'b0; word(5, 0, 1'b0); cycle();
      check("one_req", 32'(out_req), 32'h020);
      word(2, 0, 1'b0); out_ready = 1'b1; cycle();
      check("swap_req", 32'(out_req), 32'h004);
      in_valid = 1'b0; out_ready = 1'b0; cycle();
      out_ready = 1'b1; cycle();
      check("swap_single", 32'(out_valid), 32'd0);

      // out-of-range index contributes nothing
      word(13, 0, 1'b0); cycle();
      check("oob_req", 32'(out_req), 32'h000);
      in_valid = 1'b0; cycle();

      // reset with the FIFO full
      out_ready = 1'b0;
      word(7, 1, 1'b1); cycle();
      word(9, 2, 1'b1); cycle();
      in_valid = 1'b0; reset = 1'b1; cycle();
      check("mid_rst_vld", 32'(out_valid), 32'd0);
      check("mid_rst_req", 32'(out_req), 32'd0);
      reset = 1'b0; cycle();
      check("mid_rel_ready", 32'(in_ready), 32'd1);

      // malformed words and saturation
      out_ready = 1'b1;
      word(4, 7, 1'b1); cycle();
      check("bad_req", 32'(out_req), 32'h090);
`ifdef DPD_CHECK_EN
      check("bad_err", 32'(out_err), 32'd1);
      check("bad_cnt1", 32'(err_cnt), 32'd1);
`else
      check("bad_err", 32'(out_err), 32'd0);
      check("bad_cnt1", 32'(err_cnt), 32'd0);
`endif
      for (int i = 0; i < 300; i++) cycle();
`ifdef DPD_CHECK_EN
      check("sat_cnt", 32'(err_cnt), 32'd255);
`else
      check("sat_cnt", 32'(err_cnt), 32'd0);
`endif
      in_valid = 1'b0;
      reset = 1'b1; cycle(); reset = 1'b0; cycle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         in_valid      = 1'($urandom_range(0, 1));
         in_first      = IW'($urandom_range(0, 15));
         in_second     = IW'($urandom_range(0, 15));
         in_second_vld = 1'($urandom_range(0, 1));
         out_ready     = ($urandom_range(0, 3) != 0);
         reset         = ($urandom_range(0, 79) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
